// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// fetch_entry_t : one instruction buffer entry {pc, instr, arm}
// pend_entry_t  : tag kept for each in-flight memory request {pc, arm}
// NOP_*         : canonical no-op encodings for both ISAs
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        arm;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        arm;
  } pend_entry_t;

  localparam logic [31:0] NOP_RISCV = 32'h0000_0013;
  localparam logic [31:0] NOP_ARM   = 32'hE1A0_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with show-ahead head, synchronous clear and an
// occupancy count. Used both as the instruction buffer and as the tag
// queue for requests still waiting for their memory response.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   clear            empty the FIFO on the next edge (wins over push/pop)
//   push, push_data  write an entry (ignored when full and not popping)
//   pop              discard the head entry (ignored when empty)
//   head             current head entry, valid only while !empty
//   count, empty     occupancy
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage of the combined ARM/RISC-V pipeline.
// Issues word-aligned requests on a valid/ready channel, collects in-order
// variable-latency responses into an instruction buffer and presents the
// buffer head to decode. Execute-stage redirects flush the buffer and mark
// every request still in flight as wrong-path.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr   request channel
//   imem_rsp_valid, imem_rsp_data     response channel (no back-pressure)
//   RedirectE, RedirectPCE, RedirectArmE   redirect from execute
//   StallD                        decode holds its current input
//   RDD, PCF, PCPlus4F, ArmF      head instruction, its PC, PC+4, ISA mode
//   InstrValidF                   head valid (0 = bubble)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        RESET_ARM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        RedirectArmE,
  input  logic        StallD,
  output logic [31:0] RDD,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ArmF,
  output logic        InstrValidF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q;
  logic          arm_q;
  logic          started_q;
  logic [CW-1:0] drop_q;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] ibuf_count;
  logic [CW:0]   in_use;
  logic          ibuf_empty;
  logic          pend_empty;
  logic          req_fire;
  logic          rsp_take;
  logic          ibuf_push;
  logic          ibuf_pop;

  pend_entry_t   pend_head;
  pend_entry_t   pend_new;
  fetch_entry_t  ibuf_head;
  fetch_entry_t  ibuf_new;

  // The tag queue holds exactly one entry per request still owed a
  // response (wrong-path ones included), so its occupancy is the
  // outstanding count.
  assign in_use         = {1'b0, outstanding} + {1'b0, ibuf_count};
  assign imem_req_valid = started_q && !RedirectE && (in_use < (CW+1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && !pend_empty;
  assign ibuf_push      = rsp_take && !RedirectE && (drop_q == '0);
  assign ibuf_pop       = !ibuf_empty && !StallD && !RedirectE;

  assign pend_new = '{pc: pc_q, arm: arm_q};
  assign ibuf_new = '{pc: pend_head.pc, instr: imem_rsp_data, arm: pend_head.arm};

  fetch_fifo #(.WIDTH($bits(pend_entry_t)), .DEPTH(DEPTH)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .push     (req_fire),
    .push_data(pend_new),
    .pop      (rsp_take),
    .head     (pend_head),
    .count    (outstanding),
    .empty    (pend_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk      (clk),
    .rst      (rst),
    .clear    (RedirectE),
    .push     (ibuf_push),
    .push_data(ibuf_new),
    .pop      (ibuf_pop),
    .head     (ibuf_head),
    .count    (ibuf_count),
    .empty    (ibuf_empty)
  );

  // PC/mode tracking. started_q keeps the request channel quiet for the
  // first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      arm_q     <= RESET_ARM;
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (RedirectE) begin
        pc_q  <= RedirectPCE;
        arm_q <= RedirectArmE;
      end else if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // On redirect every request left in flight after this edge belongs to
  // the cancelled path; no request can fire in a redirect cycle, and a
  // response taken in that cycle is already discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (RedirectE) begin
      drop_q <= outstanding - CW'(rsp_take);
    end else if (rsp_take && (drop_q != '0)) begin
      drop_q <= drop_q - CW'(1);
    end
  end

  assign InstrValidF = !ibuf_empty;
  assign RDD         = ibuf_empty ? 32'd0 : ibuf_head.instr;
  assign PCF         = ibuf_empty ? 32'd0 : ibuf_head.pc;
  assign PCPlus4F    = ibuf_empty ? 32'd0 : ibuf_head.pc + 32'd4;
  assign ArmF        = ibuf_empty ? 1'b0  : ibuf_head.arm;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit. A behavioural memory answers
// requests in order after a configurable latency. The expected delivered
// stream is a sequence of path segments (start PC, mode); every segment is
// queued when the bench issues the reset or redirect that starts it, and a
// monitor pops segments and compares every instruction decode consumes.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic        RESET_ARM = 1'b0;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        RedirectE;
  logic [31:0] RedirectPCE;
  logic        RedirectArmE;
  logic        StallD;
  logic [31:0] RDD;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ArmF;
  logic        InstrValidF;

  typedef struct {
    logic [31:0] pc;
    logic        arm;
  } seg_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  seg_t  seg_q[$];
  mreq_t mem_q[$];

  int errors    = 0;
  int checks    = 0;
  int delivered = 0;
  int cyc       = 0;
  int lat       = 1;
  int ready_pct = 100;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .RESET_ARM(RESET_ARM)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .RedirectE     (RedirectE),
    .RedirectPCE   (RedirectPCE),
    .RedirectArmE  (RedirectArmE),
    .StallD        (StallD),
    .RDD           (RDD),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F),
    .ArmF          (ArmF),
    .InstrValidF   (InstrValidF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [31:0] base;
    base = a[4] ? NOP_ARM : NOP_RISCV;
    return base ^ (a * 32'h9E37_79B1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // stall_mode: 0 = no stall, 1 = stall, 2 = random stall
  task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                               input logic tarm, input int stall_mode);
    @(posedge clk);
    #1;
    RedirectE    = redir;
    RedirectPCE  = redir ? tgt : $urandom();
    RedirectArmE = redir ? tarm : 1'($urandom_range(0, 1));
    StallD       = (stall_mode == 1) || (stall_mode == 2 && $urandom_range(0, 3) == 0);
    if (redir) seg_q.push_back('{tgt, tarm});
  endtask

  // Behavioural instruction memory: in-order, latency >= 1, one response
  // per cycle, flushed by reset.
  initial begin
    int    due;
    int    last_due;
    mreq_t m;
    last_due       = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        mem_q.delete();
        last_due       = 0;
        imem_rsp_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        m              = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(m.addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
      end
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (rst && imem_req_valid && imem_req_ready) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{imem_addr, due});
      end
    end
  end

  // Monitor: samples mid-cycle, compares requests and consumed instructions.
  initial begin
    seg_t        cur;
    logic [31:0] exp_pc;
    logic        exp_arm;
    logic [31:0] exp_req;
    logic        in_reset;
    logic        after_release;
    logic        hold_pending;
    logic [31:0] hold_pc;
    logic [31:0] hold_rdd;
    exp_pc        = RESET_PC;
    exp_arm       = RESET_ARM;
    exp_req       = RESET_PC;
    in_reset      = 1'b0;
    after_release = 1'b0;
    hold_pending  = 1'b0;
    hold_pc       = '0;
    hold_rdd      = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!in_reset) begin
          in_reset = 1'b1;
          checkOutput("seg_queue_reset", 32'(seg_q.size() > 0), 32'd1);
          if (seg_q.size() > 0) begin
            cur     = seg_q.pop_front();
            exp_pc  = cur.pc;
            exp_arm = cur.arm;
          end
          exp_req = RESET_PC;
        end
        checkOutput("rst_valid", {31'd0, InstrValidF}, 32'd0);
        checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("rst_rdd", RDD, 32'd0);
        checkOutput("rst_pcf", PCF, 32'd0);
        checkOutput("rst_pcplus4", PCPlus4F, 32'd0);
        checkOutput("rst_arm", {31'd0, ArmF}, 32'd0);
        hold_pending  = 1'b0;
        after_release = 1'b1;
      end else begin
        in_reset = 1'b0;
        if (after_release) begin
          checkOutput("req_valid_after_release", {31'd0, imem_req_valid}, 32'd0);
          after_release = 1'b0;
        end
        if (hold_pending) begin
          checkOutput("stall_hold_valid", {31'd0, InstrValidF}, 32'd1);
          checkOutput("stall_hold_pcf", PCF, hold_pc);
          checkOutput("stall_hold_rdd", RDD, hold_rdd);
        end
        if (RedirectE) begin
          checkOutput("redirect_no_req", {31'd0, imem_req_valid}, 32'd0);
          checkOutput("seg_queue_redirect", 32'(seg_q.size() > 0), 32'd1);
          if (seg_q.size() > 0) begin
            cur     = seg_q.pop_front();
            exp_pc  = cur.pc;
            exp_arm = cur.arm;
            exp_req = cur.pc;
          end
        end else begin
          if (imem_req_valid) begin
            checkOutput("req_addr", imem_addr, exp_req);
            if (imem_req_ready) exp_req = exp_req + 32'd4;
          end
          if (InstrValidF && !StallD) begin
            checkOutput("pcf", PCF, exp_pc);
            checkOutput("rdd", RDD, instr_of(exp_pc));
            checkOutput("pcplus4f", PCPlus4F, exp_pc + 32'd4);
            checkOutput("armf", {31'd0, ArmF}, {31'd0, exp_arm});
            exp_pc = exp_pc + 32'd4;
            delivered++;
          end
        end
        hold_pending = InstrValidF && StallD && !RedirectE;
        hold_pc      = PCF;
        hold_rdd     = RDD;
      end
    end
  end

  // Directed phases followed by a randomised soak.
  initial begin
    int base;
    rst          = 1'b0;
    RedirectE    = 1'b0;
    RedirectPCE  = 32'd0;
    RedirectArmE = 1'b0;
    StallD       = 1'b0;
    seg_q.push_back('{RESET_PC, RESET_ARM});
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming at full rate, latency 1.
    base = delivered;
    repeat (20) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("p1_progress", 32'(delivered - base >= 12), 32'd1);

    // Long decode stall: buffer fills, requests stop, then resume.
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b0, 1);
    @(negedge clk);
    checkOutput("p2_full_no_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("p2_head_valid", {31'd0, InstrValidF}, 32'd1);
    base = delivered;
    repeat (10) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("p2_progress", 32'(delivered - base >= 6), 32'd1);

    // Latency 3 with requests in flight when the redirect lands.
    lat = 3;
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 0);
    base = delivered;
    repeat (15) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("p3_progress", 32'(delivered - base >= 3), 32'd1);

    // PC wrap past 2^32.
    lat = 1;
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 0);
    base = delivered;
    repeat (10) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("wrap_progress", 32'(delivered - base >= 5), 32'd1);

    // Randomised soak: ready, latency, stalls and redirects all vary.
    ready_pct = 70;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 15) == 0, $urandom() & 32'h0000_FFFC,
                    1'($urandom_range(0, 1)), 2);
    end

    // Memory not ready: address holds, buffer drains.
    ready_pct = 100;
    lat       = 1;
    repeat (8) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    ready_pct = 0;
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    @(negedge clk);
    checkOutput("p5_drained", {31'd0, InstrValidF}, 32'd0);
    checkOutput("p5_req_waiting", {31'd0, imem_req_valid}, 32'd1);
    ready_pct = 100;
    repeat (8) applyStimulus(1'b0, 32'd0, 1'b0, 0);

    // ARM-mode redirect, then reset in the middle of the stream.
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 0);
    base = delivered;
    repeat (6) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("p6_arm_progress", 32'(delivered - base >= 2), 32'd1);
    @(posedge clk);
    #1;
    seg_q.push_back('{RESET_PC, RESET_ARM});
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    base = delivered;
    repeat (20) applyStimulus(1'b0, 32'd0, 1'b0, 0);
    checkOutput("p6_restart_progress", 32'(delivered - base >= 12), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
